serial_word_tx: RTL and testbench

- Parallel-to-serial stage directly upstream of the serial two's-complement converter.
- Accepts W-bit words over a valid/ready handshake and emits them LSB first, one bit per clock, on ser_i.
- Drives ser_r, the converter's start-of-word strobe, high on bit 0 of every word and throughout idle, so the converter's carry/invert flop is cleared at each word boundary.
- A one-word holding buffer allows back-to-back words with no idle cycle.

---
 rtl/serial_word_tx_pkg.sv | 18 +
 rtl/serial_word_tx_if.sv | 11 +
 rtl/serial_word_tx.sv | 94 +++++++++
 tb/tb_serial_word_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word path: idle line levels,
// transmitter state encoding and counter sizing.
package serial_word_pkg;

   localparam logic SER_IDLE_I = 1'b0;
   localparam logic SER_IDLE_R = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_e;

   // Bit counter width; at least one bit even for single-bit words.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 32'd1) ? 32'd1 : 32'($clog2(w));
   endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Valid/ready word handshake feeding the serial transmitter.
interface serial_word_tx_if #(
   parameter int unsigned W = 4
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with a one-word holding
// buffer so consecutive words stream without an idle cycle.
module serial_word_tx
   import serial_word_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic           t_clk,
   input  logic           r,
   serial_word_tx_if.slave in_if,
   output logic           ser_i,
   output logic           ser_r,
   output logic           word_done,
   output logic           busy
);

   localparam int unsigned   CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   tx_state_e     state_q, state_d;
   logic [W-1:0]  sreg_q, sreg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  hold_data_q, hold_data_d;
   logic          hold_full_q, hold_full_d;

   logic active;
   logic last_bit;
   logic load_slot;
   logic accept;

   assign active    = (state_q == ST_SHIFT);
   assign last_bit  = (cnt_q == LAST);
   assign load_slot = !active || last_bit;

   assign in_if.in_ready = !hold_full_q && !r;
   assign accept         = in_if.in_valid && in_if.in_ready;

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;

      if (load_slot) begin
         if (hold_full_q) begin
            sreg_d  = hold_data_q;
            cnt_d   = '0;
            state_d = ST_SHIFT;
            if (accept) begin
               hold_data_d = in_if.in_data;
            end else begin
               hold_full_d = 1'b0;
            end
         end else if (accept) begin
            // Empty buffer: the new word goes straight into the shifter.
            sreg_d  = in_if.in_data;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         sreg_d = sreg_q >> 1;
         cnt_d  = cnt_q + 1'b1;
         if (accept) begin
            hold_data_d = in_if.in_data;
            hold_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge t_clk) begin
      if (r) begin
         state_q     <= ST_IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign ser_i     = active ? sreg_q[0] : SER_IDLE_I;
   assign ser_r     = active ? (cnt_q == '0) : SER_IDLE_R;
   assign word_done = active && last_bit;
   assign busy      = active || hold_full_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed vector bench for serial_word_tx at W=4 and W=1.
module tb_serial_word_tx;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [3:0] data;
      logic       rdy;
      logic       si;
      logic       sr;
      logic       wd;
      logic       bs;
   } vec_t;

   localparam int NV = 39;

   logic t_clk;
   logic r;
   logic ser_i4, ser_r4, word_done4, busy4;
   logic ser_i1, ser_r1, word_done1, busy1;

   int total;
   int bad;

   vec_t vecs [NV];

   serial_word_tx_if #(.W(4)) ifc4 ();
   serial_word_tx_if #(.W(1)) ifc1 ();

   serial_word_tx #(.W(4)) dut4 (
      .t_clk     (t_clk),
      .r         (r),
      .in_if     (ifc4),
      .ser_i     (ser_i4),
      .ser_r     (ser_r4),
      .word_done (word_done4),
      .busy      (busy4)
   );

   serial_word_tx #(.W(1)) dut1 (
      .t_clk     (t_clk),
      .r         (r),
      .in_if     (ifc1),
      .ser_i     (ser_i1),
      .ser_r     (ser_r1),
      .word_done (word_done1),
      .busy      (busy1)
   );

   initial begin
      t_clk = 1'b0;
      forever #5 t_clk = ~t_clk;
   end

   function automatic vec_t mk(input logic rst, input logic valid, input logic [3:0] data,
                               input logic rdy, input logic si, input logic sr,
                               input logic wd, input logic bs);
      vec_t v;
      v.rst = rst; v.valid = valid; v.data = data; v.rdy = rdy;
      v.si = si; v.sr = sr; v.wd = wd; v.bs = bs;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s[%0d] got=%b want=%b", name, idx, got, want);
      end
   endtask

   // Drive one cycle on the W=4 DUT: in_ready checked before the edge,
   // registered outputs checked just after it.
   task automatic apply4(input vec_t v, input int idx);
      r             = v.rst;
      ifc4.in_valid = v.valid;
      ifc4.in_data  = v.data;
      #1;
      check("rdy4", idx, ifc4.in_ready, v.rdy);
      @(posedge t_clk);
      #1;
      check("ser_i4", idx, ser_i4, v.si);
      check("ser_r4", idx, ser_r4, v.sr);
      check("done4", idx, word_done4, v.wd);
      check("busy4", idx, busy4, v.bs);
   endtask

   task automatic apply1(input logic valid, input logic data, input int idx,
                         input logic si, input logic wd, input logic bs);
      ifc1.in_valid = valid;
      ifc1.in_data  = data;
      #1;
      check("rdy1", idx, ifc1.in_ready, 1'b1);
      @(posedge t_clk);
      #1;
      check("ser_i1", idx, ser_i1, si);
      check("ser_r1", idx, ser_r1, 1'b1);
      check("done1", idx, word_done1, wd);
      check("busy1", idx, busy1, bs);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      r             = 1'b1;
      ifc4.in_valid = 1'b0;
      ifc4.in_data  = '0;
      ifc1.in_valid = 1'b0;
      ifc1.in_data  = '0;

      //                rst v  data  rdy si sr wd bs
      vecs[0]  = mk(1, 0, 4'h0, 0, 0, 1, 0, 0);
      vecs[1]  = mk(1, 0, 4'h0, 0, 0, 1, 0, 0);
      vecs[2]  = mk(0, 1, 4'h5, 1, 1, 1, 0, 1);
      vecs[3]  = mk(0, 0, 4'h0, 1, 0, 0, 0, 1);
      vecs[4]  = mk(0, 0, 4'h0, 1, 1, 0, 0, 1);
      vecs[5]  = mk(0, 0, 4'h0, 1, 0, 0, 1, 1);
      vecs[6]  = mk(0, 0, 4'h0, 1, 0, 1, 0, 0);
      vecs[7]  = mk(0, 1, 4'h3, 1, 1, 1, 0, 1);
      vecs[8]  = mk(0, 1, 4'hC, 1, 1, 0, 0, 1);
      vecs[9]  = mk(0, 0, 4'h0, 0, 0, 0, 0, 1);
      vecs[10] = mk(0, 0, 4'h0, 0, 0, 0, 1, 1);
      vecs[11] = mk(0, 0, 4'h0, 0, 0, 1, 0, 1);
      vecs[12] = mk(0, 0, 4'h0, 1, 0, 0, 0, 1);
      vecs[13] = mk(0, 0, 4'h0, 1, 1, 0, 0, 1);
      vecs[14] = mk(0, 0, 4'h0, 1, 1, 0, 1, 1);
      vecs[15] = mk(0, 0, 4'h0, 1, 0, 1, 0, 0);
      vecs[16] = mk(0, 1, 4'h1, 1, 1, 1, 0, 1);
      vecs[17] = mk(0, 1, 4'h2, 1, 0, 0, 0, 1);
      vecs[18] = mk(0, 1, 4'h4, 0, 0, 0, 0, 1);
      vecs[19] = mk(0, 1, 4'h4, 0, 0, 0, 1, 1);
      vecs[20] = mk(0, 1, 4'h4, 0, 0, 1, 0, 1);
      vecs[21] = mk(0, 1, 4'h4, 1, 1, 0, 0, 1);
      vecs[22] = mk(0, 0, 4'h0, 0, 0, 0, 0, 1);
      vecs[23] = mk(0, 0, 4'h0, 0, 0, 0, 1, 1);
      vecs[24] = mk(0, 0, 4'h0, 0, 0, 1, 0, 1);
      vecs[25] = mk(0, 0, 4'h0, 1, 0, 0, 0, 1);
      vecs[26] = mk(0, 0, 4'h0, 1, 1, 0, 0, 1);
      vecs[27] = mk(0, 0, 4'h0, 1, 0, 0, 1, 1);
      vecs[28] = mk(0, 0, 4'h0, 1, 0, 1, 0, 0);
      vecs[29] = mk(0, 1, 4'hF, 1, 1, 1, 0, 1);
      vecs[30] = mk(0, 1, 4'h7, 1, 1, 0, 0, 1);
      vecs[31] = mk(0, 0, 4'h0, 0, 1, 0, 0, 1);
      vecs[32] = mk(1, 1, 4'hA, 0, 0, 1, 0, 0);
      vecs[33] = mk(0, 0, 4'h0, 1, 0, 1, 0, 0);
      vecs[34] = mk(0, 1, 4'hA, 1, 0, 1, 0, 1);
      vecs[35] = mk(0, 0, 4'h0, 1, 1, 0, 0, 1);
      vecs[36] = mk(0, 0, 4'h0, 1, 0, 0, 0, 1);
      vecs[37] = mk(0, 0, 4'h0, 1, 1, 0, 1, 1);
      vecs[38] = mk(0, 0, 4'h0, 1, 0, 1, 0, 0);

      for (int i = 0; i < NV; i++) begin
         apply4(vecs[i], i);
      end

      // Ten idle cycles, then a word must show bit 0 one edge after acceptance.
      for (int i = 0; i < 10; i++) begin
         apply4(mk(0, 0, 4'h0, 1, 0, 1, 0, 0), 100 + i);
      end
      apply4(mk(0, 1, 4'h9, 1, 1, 1, 0, 1), 110);
      apply4(mk(0, 0, 4'h0, 1, 0, 0, 0, 1), 111);
      apply4(mk(0, 0, 4'h0, 1, 0, 0, 0, 1), 112);
      apply4(mk(0, 0, 4'h0, 1, 1, 0, 1, 1), 113);
      apply4(mk(0, 0, 4'h0, 1, 0, 1, 0, 0), 114);

      // Single-bit words: every bit starts a word and completes it.
      apply1(1'b1, 1'b1, 200, 1'b1, 1'b1, 1'b1);
      apply1(1'b1, 1'b0, 201, 1'b0, 1'b1, 1'b1);
      apply1(1'b1, 1'b1, 202, 1'b1, 1'b1, 1'b1);
      apply1(1'b0, 1'b0, 203, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
